// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencing stage: holds the PC, fetches one instruction per step,
// presents its opcode to the decoder and applies the decoder's jump/halt outcome.
module instr_fetch_unit #(
   parameter int unsigned        ADDR_W   = 8,
   parameter int unsigned        INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [7:0]         opcode,
   output logic               instr_valid,
   input  logic               exec_done,
   input  logic               jump_enable,
   input  logic [ADDR_W-1:0]  jump_target,
   input  logic               finaliza_execucao,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted
);

   typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StFetch;
         end
         StFetch: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = StIssue;
            end
         end
         StIssue: begin
            // Halt wins over jump; pc stays on the halting instruction.
            if (exec_done) begin
               if (finaliza_execucao) begin
                  state_d = StHalt;
               end else begin
                  state_d = StFetch;
                  pc_d    = jump_enable ? jump_target : pc_q + ADDR_W'(1);
               end
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
      endcase
   end

   // All outputs decode from registers only.
   assign imem_req    = (state_q == StFetch);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == StIssue);
   assign halted      = (state_q == StHalt);
   assign instr       = instr_q;
   assign opcode      = instr_q[INSTR_W-1 -: 8];
   assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, hand sequences and random
// stimulus compared against a flag-based behavioural model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready = 1'b0;
   logic [31:0] instr;
   logic [7:0]  opcode;
   logic        instr_valid;
   logic        exec_done = 1'b0;
   logic        jump_enable = 1'b0;
   logic [7:0]  jump_target = 8'h00;
   logic        finaliza_execucao = 1'b0;
   logic [7:0]  pc;
   logic        halted;

   logic [31:0] mem [256];

   int n_cmp = 0;
   int n_bad = 0;

   // Model: started / holding-instruction / halted flags instead of a state machine.
   logic        m_started, m_have, m_halted;
   logic [7:0]  m_pc;
   logic [31:0] m_instr;

   instr_fetch_unit #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
      .exec_done(exec_done), .jump_enable(jump_enable), .jump_target(jump_target),
      .finaliza_execucao(finaliza_execucao), .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;
   assign imem_rdata = mem[imem_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0; m_have = 1'b0; m_halted = 1'b0;
      m_pc = 8'h00; m_instr = 32'h0;
   endtask

   task automatic model_edge();
      if (m_halted) begin
         // terminal until reset
      end else if (!m_started) begin
         if (start) m_started = 1'b1;
      end else if (!m_have) begin
         if (imem_ready) begin
            m_instr = mem[m_pc];
            m_have  = 1'b1;
         end
      end else if (exec_done) begin
         m_have = 1'b0;
         if (finaliza_execucao) m_halted = 1'b1;
         else if (jump_enable)  m_pc = jump_target;
         else                   m_pc = 8'((int'(m_pc) + 1) % 256);
      end
   endtask

   task automatic check_all();
      logic exp_req;
      exp_req = m_started && !m_have && !m_halted;
      check("imem_req", imem_req, exp_req);
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      check("instr", instr, m_instr);
      check("opcode", opcode, m_instr[31:24]);
      check("instr_valid", instr_valid, m_have && !m_halted);
      check("pc", pc, m_pc);
      check("halted", halted, m_halted);
   endtask

   task automatic cyc(input logic s, input logic r, input logic e, input logic j,
                      input logic [7:0] t, input logic f);
      start = s; imem_ready = r; exec_done = e; jump_enable = j;
      jump_target = t; finaliza_execucao = f;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      start = 0; imem_ready = 0; exec_done = 0; jump_enable = 0;
      jump_target = 0; finaliza_execucao = 0;
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // Reset, start and jump so the unit sits in a fetch at address a.
   task automatic reach(input logic [7:0] a);
      do_reset();
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, a, 0);
   endtask

   typedef struct {
      logic [7:0] at;
      logic       jmp;
      logic [7:0] tgt;
      logic       fin;
      logic [7:0] exp_pc;
      logic       exp_halt;
   } vec_t;

   vec_t vecs [6];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h0001_0005;

      vecs[0] = '{8'h02, 1'b1, 8'h40, 1'b0, 8'h40, 1'b0};
      vecs[1] = '{8'h07, 1'b1, 8'h10, 1'b1, 8'h07, 1'b1};
      vecs[2] = '{8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[3] = '{8'h05, 1'b0, 8'h99, 1'b0, 8'h06, 1'b0};
      vecs[4] = '{8'h80, 1'b1, 8'h03, 1'b0, 8'h03, 1'b0};
      vecs[5] = '{8'h11, 1'b0, 8'h22, 1'b1, 8'h11, 1'b1};

      // Basic flow with zero-wait memory.
      do_reset();
      check("rst_req", imem_req, 1'b0);
      check("rst_pc", pc, 8'h00);
      cyc(1, 0, 0, 0, 0, 0);
      check("t1_req", imem_req, 1'b1);
      check("t1_addr", imem_addr, 8'h00);
      cyc(0, 1, 0, 0, 0, 0);
      check("t1_instr", instr, 32'h0001_0005);
      check("t1_opcode", opcode, 8'h00);
      check("t1_valid", instr_valid, 1'b1);
      cyc(0, 0, 1, 0, 0, 0);
      check("t1_pc", pc, 8'h01);
      check("t1_valid_drop", instr_valid, 1'b0);
      check("t1_addr2", imem_addr, 8'h01);

      // Wait states at pc=4.
      reach(8'h04);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 0, 0, 0);
         check("ws_req", imem_req, 1'b1);
         check("ws_addr", imem_addr, 8'h04);
         check("ws_valid", instr_valid, 1'b0);
      end
      cyc(0, 1, 0, 0, 0, 0);
      check("ws_instr", instr, mem[4]);
      check("ws_valid_rise", instr_valid, 1'b1);

      // Single retirement outcomes.
      for (int i = 0; i < 6; i++) begin
         reach(vecs[i].at);
         cyc(0, 1, 0, 0, 0, 0);
         cyc(0, 0, 1, vecs[i].jmp, vecs[i].tgt, vecs[i].fin);
         check("vec_pc", pc, vecs[i].exp_pc);
         check("vec_halted", halted, vecs[i].exp_halt);
         check("vec_req", imem_req, !vecs[i].exp_halt);
         if (vecs[i].exp_halt) begin
            for (int k = 0; k < 3; k++) cyc(1, 1, 1, 1, 8'h55, 0);
            check("halt_hold", halted, 1'b1);
            check("halt_noreq", imem_req, 1'b0);
            check("halt_pc", pc, vecs[i].exp_pc);
         end
      end

      // Asynchronous reset while fetching at 0x20.
      reach(8'h20);
      check("mf_req_pre", imem_req, 1'b1);
      #3;
      rst = 1'b0;
      #1;
      check("mf_req", imem_req, 1'b0);
      check("mf_pc", pc, 8'h00);
      check("mf_valid", instr_valid, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      check("mf_ready_ignored", instr_valid, 1'b0);
      check("mf_instr", instr, 32'h0);

      // Random run against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if (m_halted || ($urandom_range(0, 199) == 0)) begin
            do_reset();
         end else begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 4) < 2), ($urandom_range(0, 9) < 3),
                8'($urandom), ($urandom_range(0, 29) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch/sequencing stage directly upstream of the opcode decoder (control block).
- Holds the PC, fetches one instruction from instruction memory with a ready handshake, and latches it in an instruction register.
- Presents the instruction's opcode to the decoder and holds it until the execute stage retires it.
- Applies the decoder's jump_enable/finaliza_execucao outcome to pick the next PC or to halt.

Parameters:
- ADDR_W, 8, PC / instruction memory address width.
- INSTR_W, 32, instruction width; opcode = instr[INSTR_W-1:INSTR_W-8].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins execution from IDLE.
- imem_req  output  1  fetch request, held until accepted.
- imem_addr  output  ADDR_W  fetch address, equals pc while imem_req=1.
- imem_rdata  input  INSTR_W  instruction data, valid when imem_ready=1.
- imem_ready  input  1  memory accepts and returns data this cycle.
- instr  output  INSTR_W  instruction register.
- opcode  output  8  instr[INSTR_W-1:INSTR_W-8], drives the decoder.
- instr_valid  output  1  instr/opcode valid for decode/execute.
- exec_done  input  1  execute stage retires the current instruction.
- jump_enable  input  1  decoder jump flag, sampled with exec_done.
- jump_target  input  ADDR_W  jump destination, sampled with exec_done.
- finaliza_execucao  input  1  decoder halt flag, sampled with exec_done.
- pc  output  ADDR_W  address of the current/next instruction.
- halted  output  1  execution finished.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=0.
  - imem_req=0, instr_valid=0, halted=0.
- FSM states: IDLE, FETCH, ISSUE, HALT. Encoding is free. All outputs are decoded from registers, with no combinational path from any input to any output.
- IDLE:
  - Outputs idle.
  - start=1 -> FETCH at the next edge.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Edge with imem_ready=1: instr<=imem_rdata, go to ISSUE.
  - imem_ready=0: stay; req and addr stay stable.
  - Zero-wait memory gives: start edge t, req during t+1, instr_valid from t+2.
- ISSUE:
  - instr_valid=1; instr/opcode held constant.
  - On an edge with exec_done=1:
    - finaliza_execucao=1 -> HALT; pc unchanged. Halt has priority over jump.
    - else jump_enable=1 -> pc<=jump_target, go to FETCH.
    - else pc<=pc+1, modulo 2^ADDR_W (wraps all-ones -> 0), go to FETCH.
  - exec_done=0: hold.
- HALT:
  - halted=1, imem_req=0, instr_valid=0.
  - Leaves only on reset; start is ignored.
- Ignored inputs:
  - start outside IDLE.
  - imem_ready outside FETCH.
  - exec_done, jump_enable, jump_target and finaliza_execucao outside ISSUE.
- instr_valid deasserts on the edge that accepts exec_done. A new instruction is never valid in the same cycle as its retirement.
- Reset mid-FETCH: the request drops immediately (asynchronous). Any data returned afterwards is ignored.
- Reset mid-ISSUE: instr_valid drops immediately; the pc update is lost.
- Opcode values are not interpreted here. Invalid opcodes are the decoder's concern, and sequencing continues on exec_done.

Test Plan:
- Reset then start, zero-wait memory, mem[0]=0x00_01_00_05, exec_done one cycle after instr_valid -> imem_addr=0, instr=0x00010005, opcode=0x00, then pc=1 and a new fetch at addr 1.
- imem_ready held low 3 cycles in FETCH with pc=4 -> imem_req=1 and imem_addr=4 stable for 4 cycles; instr latched only on the ready edge.
- At pc=2, exec_done with jump_enable=1, jump_target=0x40 -> next imem_addr=0x40, pc=0x40.
- At pc=7, exec_done with finaliza_execucao=1 and jump_enable=1, target=0x10 -> HALT; halted=1, pc=7, no further imem_req; a later start pulse has no effect.
- ADDR_W=8, pc=0xFF, exec_done with no jump -> pc=0x00 and fetch at addr 0.
- rst asserted while imem_req=1 at pc=0x20 -> imem_req=0, pc=RESET_PC, state IDLE in the same cycle; imem_ready pulse after reset release has no effect until start.
